seq_alu: RTL and testbench
==========================

# seq_alu

Multi-cycle 16-bit ALU that sits directly downstream of the control unit, between the register file read ports and the register file write-data mux. It executes the opcode presented on `alu_sel` when `start` is pulsed, performing add, subtract, logic and shifts in one cycle and multiply and divide iteratively. It holds the result and the `zero_flag`/`pos_flag` status that feed back to the control unit's branch logic. A `busy`/`done` handshake lets the sequencer stall on long operations.

## Interface
- `WIDTH`, 16: datapath width; also the MUL/DIV iteration count.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  launch request; sampled only while `busy`=0.
- `alu_sel`  in  4  opcode: ADD=0, SUB=1, MUL=2, DIV=3, AND=4, OR=5, XOR=6, LSL=7, LSR=8, MOV=11, CMP=12.
- `imm_sel`  in  1  1: operand B = `imm_data`; 0: operand B = `rt_data`.
- `rs_data`  in  WIDTH  operand A.
- `rt_data`  in  WIDTH  register operand B.
- `imm_data`  in  WIDTH  immediate operand B.
- `result`  out  WIDTH  registered result of the last result-writing op.
- `zero_flag`  out  1  1 when the last flag-updating value equals 0.
- `pos_flag`  out  1  1 when the last flag-updating value, read as signed, is > 0.
- `busy`  out  1  high while an iterative op is in progress.
- `done`  out  1  one-cycle pulse when the op completes.
- `div_by_zero`  out  1  set by DIV with B=0; cleared by the next accepted op.

## Operation
- **Reset values:** `result`=0, `zero_flag`=0, `pos_flag`=0, `busy`=0, `done`=0, `div_by_zero`=0. The FSM enters IDLE, the counter is cleared, and any in-flight op is discarded with no `done`.
- **States:** IDLE, MULT, DIVD.
  - IDLE & `start` & MUL → MULT.
  - IDLE & `start` & DIV & B≠0 → DIVD.
  - All other accepted ops complete in IDLE.
  - MULT/DIVD return to IDLE when the counter reaches WIDTH.
- **Operand latching:** A, B and opcode are captured at the accepting edge. Input changes afterwards have no effect.
- **Single-cycle ops:**
  - ADD/SUB: modulo 2^WIDTH.
  - AND/OR/XOR: bitwise.
  - LSL/LSR: logical shift of A by B[3:0]; zero fill.
  - MOV: result = B.
- **CMP:** computes A−B. It updates the flags only; `result` is unchanged.
- **MUL:** shift-add, one bit per cycle. The result keeps the low WIDTH bits of the unsigned product.
- **DIV:** restoring, one quotient bit per cycle. The result is the unsigned quotient A/B; the remainder is discarded.
- **DIV with B=0:** completes in one cycle with `result`=all ones and `div_by_zero`=1. The flags update from all ones, giving zero=0, pos=0.
- **Unlisted opcodes (9, 10, 13–15):** accepted and `done` pulses, but `result`, the flags and `div_by_zero` are unchanged.
- **Flag updates:** every op except CMP updates the flags from the written result; CMP updates them from A−B.
- **Busy handling:** `start` while `busy`=1 is ignored entirely, not queued.

## Timing
- Let edge k be the edge that samples `start`=1 with `busy`=0.
- **Single-cycle ops:** `result`, the flags and `done`=1 are valid after edge k. `done` drops after edge k+1 unless a new op is accepted.
- **MUL/DIV:**
  - `busy`=1 after edge k.
  - Iteration steps occur on edges k+1 through k+WIDTH.
  - At edge k+WIDTH: `result` and the flags are written, `busy`=0 and `done`=1.
  - Total latency is WIDTH+1 cycles (17 at the default width).
- `result` and the flags hold their value during `busy`; there are no intermediate values.
- **Back-to-back:** `start` sampled in the `done` cycle is accepted, since `busy`=0.
- **Reset priority:** `reset` overrides `start` on the same edge.

## Test plan
- **Reset and ADD:** reset, then ADD A=0x7FFF, B=0x0001 with `imm_sel`=0 → after 1 cycle `result`=0x8000, zero=0, pos=0, `done` pulses once.
- **SUB and CMP:** SUB 5−5 → `result`=0, zero=1; then CMP A=3, B(imm)=1 → zero=0, pos=1, `result` still 0.
- **MUL:** MUL 0x0123×0x0010 → `busy` high for 16 cycles, then `result`=0x1230 and `done` at cycle 17. A second `start` issued mid-operation is ignored.
- **DIV:** DIV 1000/7 → `result`=142 after 17 cycles; then DIV 5/0 → `result`=0xFFFF, `div_by_zero`=1 after 1 cycle; then ADD clears `div_by_zero`.
- **Shifts:** LSL 0x0001 by imm 0x0013 → `result`=0x0008 (B[3:0]=3); LSR 0x8000 by 15 → 0x0001.
- **Reset mid-operation:** reset asserted 5 cycles into a DIV → next cycle `busy`=0, `result`=0, no `done` pulse, and a following ADD works normally.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU between the register file read ports and the
// write-data mux. ADD/SUB/logic/shift/MOV/CMP finish in one cycle; MUL
// (shift-add) and DIV (restoring) take one iteration per bit, WIDTH in all.
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   start                launch request, sampled only while busy is low
//   alu_sel              opcode (ADD=0 SUB=1 MUL=2 DIV=3 AND=4 OR=5 XOR=6
//                        LSL=7 LSR=8 MOV=11 CMP=12, others are no-ops)
//   imm_sel              selects imm_data (1) or rt_data (0) as operand B
//   rs_data              operand A
//   rt_data, imm_data    operand B candidates
//   result               registered result of the last result-writing op
//   zero_flag, pos_flag  status of the last flag-updating value
//   busy                 iterative op in progress
//   done                 one-cycle completion pulse
//   div_by_zero          last DIV had a zero divisor
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_sel,
    input  logic             imm_sel,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic [WIDTH-1:0] imm_data,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             pos_flag,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_LSL = 4'd7;
    localparam logic [3:0] OP_LSR = 4'd8;
    localparam logic [3:0] OP_MOV = 4'd11;
    localparam logic [3:0] OP_CMP = 4'd12;

    typedef enum logic [1:0] {IDLE, MULT, DIVD} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    // MUL: opa = shifting multiplicand, opb = shifting multiplier, acc = product.
    // DIV: opa = dividend shifting out / quotient shifting in, opb = divisor,
    //      acc = partial remainder.
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             pos_q, pos_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] alu_val;
    logic             wr_result;
    logic             flag_we;
    logic [WIDTH-1:0] acc_step;
    logic [WIDTH:0]   rem_shift;
    logic             rem_fits;
    logic [WIDTH-1:0] quo_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            pos_q    <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            pos_q    <= pos_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        result_d  = result_q;
        zero_d    = zero_q;
        pos_d     = pos_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;
        alu_val   = '0;
        wr_result = 1'b0;
        flag_we   = 1'b0;

        operand_b = imm_sel ? imm_data : rt_data;

        acc_step  = opb_q[0] ? acc_q + opa_q : acc_q;

        // Restoring divide: bring down the next dividend bit, subtract the
        // divisor only when it fits, and shift the quotient bit in at the bottom.
        rem_shift = {acc_q, opa_q[WIDTH-1]};
        rem_fits  = rem_shift >= {1'b0, opb_q};
        quo_next  = {opa_q[WIDTH-2:0], rem_fits};

        case (state_q)
            IDLE: begin
                if (start) begin
                    done_d = 1'b1;
                    dbz_d  = 1'b0;
                    case (alu_sel)
                        OP_ADD: begin alu_val = rs_data + operand_b;         wr_result = 1'b1; flag_we = 1'b1; end
                        OP_SUB: begin alu_val = rs_data - operand_b;         wr_result = 1'b1; flag_we = 1'b1; end
                        OP_AND: begin alu_val = rs_data & operand_b;         wr_result = 1'b1; flag_we = 1'b1; end
                        OP_OR:  begin alu_val = rs_data | operand_b;         wr_result = 1'b1; flag_we = 1'b1; end
                        OP_XOR: begin alu_val = rs_data ^ operand_b;         wr_result = 1'b1; flag_we = 1'b1; end
                        OP_LSL: begin alu_val = rs_data << operand_b[3:0];   wr_result = 1'b1; flag_we = 1'b1; end
                        OP_LSR: begin alu_val = rs_data >> operand_b[3:0];   wr_result = 1'b1; flag_we = 1'b1; end
                        OP_MOV: begin alu_val = operand_b;                   wr_result = 1'b1; flag_we = 1'b1; end
                        OP_CMP: begin alu_val = rs_data - operand_b;         flag_we = 1'b1; end
                        OP_MUL: begin
                            state_d = MULT;
                            done_d  = 1'b0;
                            count_d = '0;
                            opa_d   = rs_data;
                            opb_d   = operand_b;
                            acc_d   = '0;
                        end
                        OP_DIV: begin
                            // A zero divisor short-circuits to all ones in one cycle.
                            if (operand_b == '0) begin
                                alu_val   = '1;
                                wr_result = 1'b1;
                                flag_we   = 1'b1;
                                dbz_d     = 1'b1;
                            end else begin
                                state_d = DIVD;
                                done_d  = 1'b0;
                                count_d = '0;
                                opa_d   = rs_data;
                                opb_d   = operand_b;
                                acc_d   = '0;
                            end
                        end
                        default: begin
                            // Reserved opcodes only acknowledge; all status is kept.
                            dbz_d = dbz_q;
                        end
                    endcase
                end
            end
            MULT: begin
                acc_d   = acc_step;
                opa_d   = opa_q << 1;
                opb_d   = opb_q >> 1;
                count_d = count_q + 1'b1;
                if (count_q == LAST) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    alu_val   = acc_step;
                    wr_result = 1'b1;
                    flag_we   = 1'b1;
                end
            end
            DIVD: begin
                acc_d   = rem_fits ? rem_shift[WIDTH-1:0] - opb_q : rem_shift[WIDTH-1:0];
                opa_d   = quo_next;
                count_d = count_q + 1'b1;
                if (count_q == LAST) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    alu_val   = quo_next;
                    wr_result = 1'b1;
                    flag_we   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr_result) begin
            result_d = alu_val;
        end
        if (flag_we) begin
            zero_d = (alu_val == '0);
            pos_d  = !alu_val[WIDTH-1] && (alu_val != '0);
        end
    end

    assign result      = result_q;
    assign zero_flag   = zero_q;
    assign pos_flag    = pos_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized plus directed bench for seq_alu. A driver issues ops
// and pushes the expected completion (value, flags, completion cycle) into a
// scoreboard queue; a monitor compares whenever done is seen and otherwise
// checks that the visible state holds and busy matches the expected window.
module tb_seq_alu;

    localparam int W = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [3:0]    alu_sel;
    logic          imm_sel;
    logic [W-1:0]  rs_data;
    logic [W-1:0]  rt_data;
    logic [W-1:0]  imm_data;
    logic [W-1:0]  result;
    logic          zero_flag;
    logic          pos_flag;
    logic          busy;
    logic          done;
    logic          div_by_zero;

    seq_alu #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .alu_sel     (alu_sel),
        .imm_sel     (imm_sel),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .imm_data    (imm_data),
        .result      (result),
        .zero_flag   (zero_flag),
        .pos_flag    (pos_flag),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clock) cyc++;

    typedef struct {
        logic [W-1:0] res;
        bit           z;
        bit           p;
        bit           dbz;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    exp_t cur = '{res: '0, z: 1'b0, p: 1'b0, dbz: 1'b0, cyc: 0};

    int busy_from = 0;
    int busy_to   = -1;

    // Reference architectural state.
    logic [W-1:0] m_res = '0;
    bit           m_z   = 1'b0;
    bit           m_p   = 1'b0;
    bit           m_dbz = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Drives one op and records what the reference model expects from it.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] rt,
                         input logic [W-1:0] imm, input bit isel, output bit iter);
        logic [W-1:0] b;
        logic [W-1:0] v;
        logic [31:0]  prod;
        bit           wr;
        bit           fl;
        exp_t         e;
        int           k;
        b    = isel ? imm : rt;
        k    = cyc + 1;
        v    = '0;
        wr   = 1'b0;
        fl   = 1'b0;
        iter = 1'b0;
        rs_data  = a;
        rt_data  = rt;
        imm_data = imm;
        imm_sel  = isel;
        alu_sel  = op;
        start    = 1'b1;
        case (op)
            4'd0:  begin v = a + b; wr = 1; end
            4'd1:  begin v = a - b; wr = 1; end
            4'd2:  begin prod = 32'(a) * 32'(b); v = prod[W-1:0]; wr = 1; iter = 1; end
            4'd3:  begin
                       if (b == 0) v = '1;
                       else begin v = a / b; iter = 1; end
                       wr = 1;
                   end
            4'd4:  begin v = a & b; wr = 1; end
            4'd5:  begin v = a | b; wr = 1; end
            4'd6:  begin v = a ^ b; wr = 1; end
            4'd7:  begin v = a << b[3:0]; wr = 1; end
            4'd8:  begin v = a >> b[3:0]; wr = 1; end
            4'd11: begin v = b; wr = 1; end
            4'd12: begin v = a - b; fl = 1; end
            default: ;
        endcase
        if (wr) m_res = v;
        if (wr || fl) begin
            m_z   = (v == 0);
            m_p   = ($signed(v) > 0);
            m_dbz = (op == 4'd3) && (b == 0);
        end
        e.res = m_res;
        e.z   = m_z;
        e.p   = m_p;
        e.dbz = m_dbz;
        if (iter) begin
            e.cyc     = k + W;
            busy_from = k;
            busy_to   = k + W - 1;
        end else begin
            e.cyc = k;
        end
        sb.push_back(e);
    endtask

    // Issues an op, then lets it run to completion while scribbling on the
    // inputs (including spurious start pulses that must be ignored). Returns
    // on the falling edge of the done cycle so the next op can follow directly.
    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] rt,
                                 input logic [W-1:0] imm, input bit isel);
        bit iter;
        issue(op, a, rt, imm, isel, iter);
        @(negedge clock);
        start = 1'b0;
        if (iter) begin
            for (int i = 0; i < W; i++) begin
                start    = 1'($urandom_range(0, 1));
                alu_sel  = 4'($urandom);
                rs_data  = 16'($urandom);
                rt_data  = 16'($urandom);
                imm_data = 16'($urandom);
                imm_sel  = 1'($urandom);
                @(negedge clock);
            end
            start = 1'b0;
        end
    endtask

    task automatic resetDut(input bit with_start, input int cycles);
        reset   = 1'b1;
        start   = with_start;
        alu_sel = 4'd0;
        rs_data = 16'h1234;
        rt_data = 16'h0001;
        sb.delete();
        busy_to = -1;
        m_res   = '0;
        m_z     = 1'b0;
        m_p     = 1'b0;
        m_dbz   = 1'b0;
        cur     = '{res: '0, z: 1'b0, p: 1'b0, dbz: 1'b0, cyc: 0};
        repeat (cycles) @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        exp_t e;
        bit   exp_busy;
        forever begin
            @(posedge clock);
            #1;
            exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
            checkOutput("busy", 32'(busy), 32'(exp_busy));
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL missing_done at cycle %0d: got no done, expected done at cycle %0d", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (done) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_done at cycle %0d: got done=1, expected done=0", cyc);
                end else begin
                    e = sb.pop_front();
                    checkOutput("done_cycle", 32'(cyc), 32'(e.cyc));
                    checkOutput("result", 32'(result), 32'(e.res));
                    checkOutput("zero_flag", 32'(zero_flag), 32'(e.z));
                    checkOutput("pos_flag", 32'(pos_flag), 32'(e.p));
                    checkOutput("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                    cur = e;
                end
            end else begin
                checkOutput("hold_result", 32'(result), 32'(cur.res));
                checkOutput("hold_zero", 32'(zero_flag), 32'(cur.z));
                checkOutput("hold_pos", 32'(pos_flag), 32'(cur.p));
                if (!exp_busy) checkOutput("hold_dbz", 32'(div_by_zero), 32'(cur.dbz));
            end
        end
    end

    initial begin
        bit           dummy;
        logic [3:0]   op;
        logic [W-1:0] a, rt, imm;
        bit           isel;
        int           gap;

        reset    = 1'b1;
        start    = 1'b0;
        alu_sel  = '0;
        imm_sel  = 1'b0;
        rs_data  = '0;
        rt_data  = '0;
        imm_data = '0;
        @(negedge clock);
        // start held high during reset must be overridden
        resetDut(1'b1, 2);

        applyStimulus(4'd0,  16'h7FFF, 16'h0001, 16'h0000, 1'b0);
        applyStimulus(4'd1,  16'd5,    16'd5,    16'h0000, 1'b0);
        applyStimulus(4'd12, 16'd3,    16'h0000, 16'd1,    1'b1);
        applyStimulus(4'd2,  16'h0123, 16'h0010, 16'h0000, 1'b0);
        applyStimulus(4'd3,  16'd1000, 16'd7,    16'h0000, 1'b0);
        applyStimulus(4'd3,  16'd5,    16'd0,    16'h0000, 1'b0);
        applyStimulus(4'd0,  16'd1,    16'd2,    16'h0000, 1'b0);
        applyStimulus(4'd7,  16'h0001, 16'h0000, 16'h0013, 1'b1);
        applyStimulus(4'd8,  16'h8000, 16'd15,   16'h0000, 1'b0);
        applyStimulus(4'd11, 16'h0000, 16'h0000, 16'hFFFE, 1'b1);
        applyStimulus(4'd3,  16'd9,    16'd0,    16'h0000, 1'b0);
        applyStimulus(4'd9,  16'h00AA, 16'h0055, 16'h0000, 1'b0);
        repeat (2) @(negedge clock);

        // Reset five cycles into a divide: no done, state cleared.
        issue(4'd3, 16'd1000, 16'd7, 16'h0000, 1'b0, dummy);
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        resetDut(1'b0, 1);
        applyStimulus(4'd0, 16'd20, 16'd22, 16'h0000, 1'b0);

        for (int n = 0; n < 200; n++) begin
            op   = 4'($urandom);
            a    = 16'($urandom);
            rt   = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            imm  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            isel = 1'($urandom);
            applyStimulus(op, a, rt, imm, isel);
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clock);
        end

        repeat (3) @(negedge clock);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL pending_ops at end: got %0d outstanding, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout at cycle %0d: got no finish, expected finish", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
